param_updown_counter: RTL



---
 rtl/param_updown_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with wrap, saturate and one-shot modes
// Optional Gray-coded count output enabled by PARAM_COUNTER_GRAY_OUT_EN.
module param_updown_counter #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             busy,
   output logic             done
`ifdef PARAM_COUNTER_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] count_gray
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   state_t           r_state, w_nxt_state;
   logic [WIDTH-1:0] r_count, w_nxt_count;
   logic             r_tc, w_nxt_tc;
   logic             r_ovf, w_nxt_ovf;
   logic             r_busy, w_nxt_busy;
   logic             r_done, w_nxt_done;
   logic [WIDTH-1:0] w_target;
   logic [WIDTH-1:0] w_origin;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_load_sat;
   logic             w_term;

   // The terminal follows the live direction, so flipping up mid-run retargets at once.
   assign w_target   = up ? MAX_COUNT : '0;
   assign w_origin   = up ? '0 : MAX_COUNT;
   assign w_term     = (r_count == w_target);
   assign w_step     = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
   assign w_load_sat = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_count = r_count;
      w_nxt_tc    = 1'b0;
      w_nxt_ovf   = r_ovf;
      w_nxt_busy  = r_busy;
      w_nxt_done  = 1'b0;
      if (load) begin
         w_nxt_count = w_load_sat;
         w_nxt_ovf   = 1'b0;
         w_nxt_state = S_IDLE;
         w_nxt_busy  = 1'b0;
      end else if (r_state != S_IDLE && mode != MODE_ONESHOT) begin
         // Leaving one-shot mid-run aborts silently and keeps the count.
         w_nxt_state = S_IDLE;
         w_nxt_busy  = 1'b0;
      end else begin
         case (mode)
            MODE_WRAP: begin
               if (enable) begin
                  if (w_term) begin
                     w_nxt_count = w_origin;
                     w_nxt_tc    = 1'b1;
                     w_nxt_ovf   = 1'b1;
                  end else begin
                     w_nxt_count = w_step;
                  end
               end
            end
            MODE_SAT: begin
               if (enable) begin
                  if (w_term) begin
                     w_nxt_tc  = 1'b1;
                     w_nxt_ovf = 1'b1;
                  end else begin
                     w_nxt_count = w_step;
                  end
               end
            end
            MODE_ONESHOT: begin
               case (r_state)
                  S_IDLE: begin
                     if (start) begin
                        w_nxt_state = S_RUN;
                        w_nxt_count = w_origin;
                        w_nxt_busy  = 1'b1;
                     end
                  end
                  S_RUN: begin
                     if (enable) begin
                        if (!w_term) begin
                           w_nxt_count = w_step;
                        end
                        if (w_term || w_step == w_target) begin
                           w_nxt_state = S_DONE;
                           w_nxt_busy  = 1'b0;
                           w_nxt_done  = 1'b1;
                           w_nxt_tc    = 1'b1;
                        end
                     end
                  end
                  default: begin
                     w_nxt_state = S_IDLE;
                  end
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= RESET_VAL;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_count <= w_nxt_count;
         r_tc    <= w_nxt_tc;
         r_ovf   <= w_nxt_ovf;
         r_busy  <= w_nxt_busy;
         r_done  <= w_nxt_done;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;
   assign busy  = r_busy;
   assign done  = r_done;

`ifdef PARAM_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] r_gray;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gray <= RESET_VAL ^ (RESET_VAL >> 1);
      end else begin
         r_gray <= w_nxt_count ^ (w_nxt_count >> 1);
      end
   end

   assign count_gray = r_gray;
`endif

endmodule
